// File: rtl/four_12_12_st2_bias_ctrl_pkg.sv
// Shared types and constants for the stage-2 bias memory controller.
// Holds the memory port struct, the controller FSM states and the saturating adder.
package four_12_12_st2_bias_ctrl_pkg;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] BIAS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] BIAS_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic              rd_en;
        logic [ADDR_W-1:0] rd_addr;
    } bias_int_32_4_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_UPDATE,
        ST_STREAM
    } state_e;

    // Overflow shows up as the two top bits of the sign-extended sum disagreeing.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            return sum[DATA_W] ? BIAS_MIN : BIAS_MAX;
        end
        return sum[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/four_12_12_st2_bias_skid.sv
// Two-entry FIFO that buffers streamed bias words (plus last flag) so that
// reads already in flight are never lost when the consumer stalls.
module four_12_12_st2_bias_skid
    import four_12_12_st2_bias_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic [1:0]        count_o
);

    logic [DATA_W:0] entry_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;
    logic            push;
    logic            pop;

    assign out_valid_o = (count_q != 2'd0);
    assign pop         = out_valid_o & out_ready_i;
    assign push        = in_valid_i & (count_q != 2'd2);
    assign out_data_o  = entry_q[rd_ptr_q][DATA_W-1:0];
    assign out_last_o  = out_valid_o & entry_q[rd_ptr_q][DATA_W];
    assign count_o     = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= {in_last_i, in_data_i};
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/four_12_12_st2_bias_ctrl.sv
// Sole master of the stage-2 bias memory: bulk load, saturating training
// updates by read-modify-write, and streaming of all biases to the accumulator.
module four_12_12_st2_bias_ctrl
    import four_12_12_st2_bias_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              upd_valid_i,
    output logic              upd_ready_o,
    input  logic [DATA_W-1:0] upd_data_i,
    input  logic              strm_req_i,
    output logic              strm_ack_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output bias_int_32_4_t    bias_int_o,
    output logic [DATA_W-1:0] bias_int_wr_data_o,
    input  logic [DATA_W-1:0] bias_int_rd_data_i
);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              phase_b_q;
    logic              last_issued_q;
    logic              rd_pend_q;
    logic              rd_pend_last_q;
    logic              load_ready_q;
    logic              upd_ready_q;
    logic              strm_ack_q;
    logic              busy_q;

    logic              cnt_at_end;
    logic [ADDR_W-1:0] cnt_next;
    logic              load_fire;
    logic              upd_read;
    logic              upd_write;
    logic              strm_read;
    logic              skid_pop;
    logic [1:0]        skid_count;
    logic [2:0]        credit;

    assign cnt_at_end = (cnt_q == ADDR_W'(DEPTH - 1));
    assign cnt_next   = cnt_at_end ? '0 : cnt_q + ADDR_W'(1);
    assign load_fire  = (state_q == ST_LOAD) & load_valid_i;
    assign upd_read   = (state_q == ST_UPDATE) & ~phase_b_q & upd_valid_i;
    assign upd_write  = (state_q == ST_UPDATE) & phase_b_q;
    assign skid_pop   = out_valid_o & out_ready_i;

    // A word leaving the buffer this cycle frees its slot in time for a read issued now.
    assign credit    = {1'b0, skid_count} - {2'b00, skid_pop} + {2'b00, rd_pend_q};
    assign strm_read = (state_q == ST_STREAM) & ~last_issued_q & (credit < 3'd2);

    assign load_ready_o = load_ready_q;
    assign upd_ready_o  = upd_ready_q;
    assign strm_ack_o   = strm_ack_q;
    assign busy_o       = busy_q;

    always_comb begin
        bias_int_o         = '0;
        bias_int_wr_data_o = '0;
        if (load_fire) begin
            bias_int_o.wr_en   = 1'b1;
            bias_int_o.wr_addr = cnt_q;
            bias_int_wr_data_o = load_data_i;
        end else if (upd_write) begin
            bias_int_o.wr_en   = 1'b1;
            bias_int_o.wr_addr = cnt_q;
            bias_int_wr_data_o = sat_add(bias_int_rd_data_i, upd_data_i);
        end
        if (upd_read || strm_read) begin
            bias_int_o.rd_en   = 1'b1;
            bias_int_o.rd_addr = cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            phase_b_q      <= 1'b0;
            last_issued_q  <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            load_ready_q   <= 1'b0;
            upd_ready_q    <= 1'b0;
            strm_ack_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            strm_ack_q     <= 1'b0;
            rd_pend_q      <= strm_read;
            rd_pend_last_q <= strm_read & cnt_at_end;
            case (state_q)
                ST_IDLE: begin
                    cnt_q         <= '0;
                    phase_b_q     <= 1'b0;
                    last_issued_q <= 1'b0;
                    if (load_valid_i) begin
                        state_q      <= ST_LOAD;
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (upd_valid_i) begin
                        state_q <= ST_UPDATE;
                        busy_q  <= 1'b1;
                    end else if (strm_req_i) begin
                        state_q    <= ST_STREAM;
                        strm_ack_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_valid_i) begin
                        cnt_q <= cnt_next;
                        if (cnt_at_end) begin
                            state_q      <= ST_IDLE;
                            load_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (phase_b_q) begin
                        phase_b_q   <= 1'b0;
                        upd_ready_q <= 1'b0;
                        cnt_q       <= cnt_next;
                        if (cnt_at_end) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (upd_valid_i) begin
                        phase_b_q   <= 1'b1;
                        upd_ready_q <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (strm_read) begin
                        cnt_q <= cnt_next;
                        if (cnt_at_end) begin
                            last_issued_q <= 1'b1;
                        end
                    end
                    if (last_issued_q && skid_pop && out_last_o) begin
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        last_issued_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    four_12_12_st2_bias_skid u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (rd_pend_q),
        .in_data_i   (bias_int_rd_data_i),
        .in_last_i   (rd_pend_last_q),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .count_o     (skid_count)
    );

    a_no_rd_wr_same_addr : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bias_int_o.wr_en && bias_int_o.rd_en && (bias_int_o.wr_addr == bias_int_o.rd_addr)));

    a_skid_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rd_pend_q && (skid_count == 2'd2) && !skid_pop));

endmodule
